xor_key_lock_pipe: RTL and testbench
====================================

// Module: xor_key_lock_pipe
// PURPOSE
//  Parametrised XOR key-gate datapath with a sequentially loaded key. A KEY_W-bit key is shifted
//  in serially and armed; then each DATA_W-bit word is XORed with the expanded key through a
//  STAGES-deep valid/ready pipeline. It sits between primary inputs and a locked core, and it
//  replaces hard-wired key inputs with a loadable and clearable key register.
// PARAMETERS
//  DATA_W   36                   width of the data word
//  KEY_W    32                   key length in bits; range 1..DATA_W
//  STAGES   2                    number of pipeline register stages; range 1..4
//  CNT_W    $clog2(KEY_W+1)      width of the key bit counter (derived)
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  key_bit_i    in   1        serial key bit, LSB first
//  key_vld_i    in   1        key_bit_i is valid this cycle
//  key_clr_i    in   1        clear key, return to IDLE, flush pipeline
//  key_armed_o  out  1        full key loaded; datapath enabled
//  key_err_o    out  1        sticky: key_vld_i was seen while ARMED
//  in_vld_i     in   1        input word valid
//  in_rdy_o     out  1        input word accepted when in_vld_i & in_rdy_o
//  in_data_i    in   DATA_W   plaintext word
//  out_vld_o    out  1        output word valid
//  out_rdy_i    in   1        downstream ready
//  out_data_o   out  DATA_W   in_data ^ expand(key)
// BEHAVIOUR
//  Reset: FSM=IDLE, key=0, cnt=0, all stage valids=0. key_armed_o, key_err_o, in_rdy_o and
//   out_vld_o are 0. out_data_o=0.
//  FSM IDLE: key_vld_i -> LOAD. The bit is shifted in at key[KEY_W-1] with a right shift, so after
//   KEY_W bits the first bit is key[0]. cnt is set to 1.
//  FSM LOAD: each key_vld_i shifts in one bit and increments cnt. When the bit that makes
//   cnt==KEY_W is accepted -> ARMED. key_armed_o=1 from the next cycle.
//  FSM ARMED: key_vld_i is ignored and sets key_err_o. key_err_o clears only on reset or key_clr_i.
//  key_clr_i in any state has priority over key_vld_i. It causes, in the next cycle: key=0, cnt=0,
//   FSM=IDLE, key_armed_o=0, key_err_o=0, all stage valids=0. In-flight words are dropped.
//  Expansion: exp[j] = key[j % KEY_W] for j in 0..DATA_W-1.
//  The XOR is applied combinationally at stage-0 capture. The stored key is stable while ARMED.
//  in_rdy_o = ARMED & ~key_clr_i & (~stage0_vld | stage0_advances).
//  A stage advances when the next stage is empty or will advance. The last stage advances on
//   out_rdy_i.
//  Pipeline rules:
//   - Full throughput: one word per cycle while out_rdy_i=1.
//   - Latency: accept at cycle t -> out_vld_o at t+STAGES if there is no stall.
//   - out_data_o and out_vld_o hold stable while out_vld_o & ~out_rdy_i.
//   - No word is lost or duplicated under any stall pattern.
//   - out_data_o holds the last value when out_vld_o=0. It is not zeroed, except on reset and
//     key_clr_i.
//  Simultaneous accept and key_clr_i: key_clr_i wins and in_rdy_o is already 0.
//  Reset mid-load clears everything. A partial key is never armed.
// STRUCTURE
//  Shared package xlock_pkg holds typedef enum logic [1:0] {IDLE, LOAD, ARMED} xlock_state_t and the
//   function expand_key(key) used by both RTL and bench.
//  One sub-module, xlock_pipe_stage: a DATA_W+1 register slice (data+valid) with a ready chain.
//   STAGES instances are generated.
//  The FSM, shift register and counter stay in the top module.
// TESTING
//  T1 reset: assert rst_n=0 mid-traffic -> all outputs 0 at once (asynchronously), FSM=IDLE.
//  T2 load 0xA5A5A5A5 LSB-first (32 pulses), then data 36'h0 -> key_armed_o=1,
//   out_data_o=36'h5_A5A5_A5A5 two cycles after accept (STAGES=2).
//  T3 backpressure: stream 8 words with random out_rdy_i -> in-order, intact, none dropped,
//   output stable during stalls.
//  T4 key_clr_i after 17 key bits -> cnt=0, IDLE. A fresh 32-bit load then arms correctly,
//   with no residue from the partial key.
//  T5 key_vld_i while ARMED -> key_err_o=1 next cycle and the key is unchanged.
//   key_clr_i -> key_err_o=0 and key_armed_o=0.
//  T6 key_clr_i with 2 words in flight -> out_vld_o=0 next cycle and the words never appear.
//   Repeat with STAGES=1, KEY_W=DATA_W=8.

Source files
------------

// File: rtl/xlock_pkg.sv
// rtl/xlock_pkg.sv - shared FSM state type and key expansion for the XOR key-lock pipe
package xlock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } xlock_state_t;

  localparam int unsigned EXP_MAX_W = 64;

  // Repeats the key across the data width: bit j takes key bit (j mod key_w).
  function automatic logic [EXP_MAX_W-1:0] expand_key(
    input logic [EXP_MAX_W-1:0] key,
    input int unsigned          key_w,
    input int unsigned          data_w
  );
    logic [EXP_MAX_W-1:0] res;
    res = '0;
    for (int unsigned j = 0; j < EXP_MAX_W; j++) begin
      if (j < data_w) begin
        res[j] = key[j % key_w];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/xlock_pipe_stage.sv
// rtl/xlock_pipe_stage.sv - one data+valid register slice of the XOR key-lock pipeline
module xlock_pipe_stage
  import xlock_pkg::*;
#(
  parameter int unsigned DATA_W = 36
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              up_vld_i,
  input  logic [DATA_W-1:0] up_data_i,
  input  logic              dn_rdy_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              load;

  assign load = ~vld_q | dn_rdy_i;

  // Data only changes when a real word arrives, so a bubble keeps the last value visible.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (clr_i) begin
      vld_d  = 1'b0;
      data_d = '0;
    end else if (load) begin
      vld_d = up_vld_i;
      if (up_vld_i) begin
        data_d = up_data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/xor_key_lock_pipe.sv
// rtl/xor_key_lock_pipe.sv - serially loaded XOR key gate feeding a valid/ready pipeline
module xor_key_lock_pipe
  import xlock_pkg::*;
#(
  parameter int unsigned DATA_W = 36,
  parameter int unsigned KEY_W  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = $clog2(KEY_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_bit_i,
  input  logic              key_vld_i,
  input  logic              key_clr_i,
  output logic              key_armed_o,
  output logic              key_err_o,
  input  logic              in_vld_i,
  output logic              in_rdy_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_vld_o,
  input  logic              out_rdy_i,
  output logic [DATA_W-1:0] out_data_o
);

  xlock_state_t     state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d, key_shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             err_q, err_d;

  // New bits enter at the MSB so the first bit sent ends up at key[0].
  assign key_shifted = (key_q >> 1) | (KEY_W'(key_bit_i) << (KEY_W - 1));

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (key_clr_i) begin
      state_d = IDLE;
      key_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (key_vld_i) begin
      case (state_q)
        IDLE: begin
          key_d   = key_shifted;
          cnt_d   = CNT_W'(1);
          state_d = (KEY_W == 1) ? ARMED : LOAD;
        end
        LOAD: begin
          key_d = key_shifted;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(KEY_W - 1)) begin
            state_d = ARMED;
          end
        end
        ARMED:   err_d   = 1'b1;
        default: state_d = IDLE;
      endcase
    end
    armed_d = (state_d == ARMED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      err_q   <= err_d;
    end
  end

  assign key_armed_o = armed_q;
  assign key_err_o   = err_q;

  logic [DATA_W-1:0] exp_key;
  logic [DATA_W-1:0] in_xor;
  logic              in_acc;
  logic [STAGES-1:0] stage_vld;
  logic [DATA_W-1:0] stage_data [STAGES];
  logic [STAGES:0]   chain_rdy;

  assign exp_key = DATA_W'(expand_key(EXP_MAX_W'(key_q), KEY_W, DATA_W));
  assign in_xor  = in_data_i ^ exp_key;

  // Stage s can take a word when it or any stage downstream of it has a free slot.
  always_comb begin
    chain_rdy         = '0;
    chain_rdy[STAGES] = out_rdy_i;
    for (int s = int'(STAGES) - 1; s >= 0; s--) begin
      chain_rdy[s] = ~stage_vld[s] | chain_rdy[s+1];
    end
  end

  assign in_rdy_o = armed_q & ~key_clr_i & chain_rdy[0];
  assign in_acc   = in_vld_i & in_rdy_o;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic              up_vld;
    logic [DATA_W-1:0] up_data;
    if (s == 0) begin : g_first
      assign up_vld  = in_acc;
      assign up_data = in_xor;
    end else begin : g_next
      assign up_vld  = stage_vld[s-1];
      assign up_data = stage_data[s-1];
    end
    xlock_pipe_stage #(
      .DATA_W(DATA_W)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (key_clr_i),
      .up_vld_i (up_vld),
      .up_data_i(up_data),
      .dn_rdy_i (chain_rdy[s+1]),
      .vld_o    (stage_vld[s]),
      .data_o   (stage_data[s])
    );
  end

  assign out_vld_o  = stage_vld[STAGES-1];
  assign out_data_o = stage_data[STAGES-1];

endmodule

// File: tb/tb_xor_key_lock_pipe.sv
// tb/tb_xor_key_lock_pipe.sv - randomized self-checking bench for two xor_key_lock_pipe configurations
module tb_xor_key_lock_pipe;
  import xlock_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_key_bit = 0, a_key_vld = 0, a_key_clr = 0, a_in_vld = 0, a_out_rdy = 0;
  logic [35:0] a_in_data = '0, a_out_data;
  logic        a_armed, a_err, a_in_rdy, a_out_vld;

  logic        b_key_bit = 0, b_key_vld = 0, b_key_clr = 0, b_in_vld = 0, b_out_rdy = 0;
  logic [7:0]  b_in_data = '0, b_out_data;
  logic        b_armed, b_err, b_in_rdy, b_out_vld;

  xor_key_lock_pipe #(.DATA_W(36), .KEY_W(32), .STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .key_bit_i(a_key_bit), .key_vld_i(a_key_vld), .key_clr_i(a_key_clr),
    .key_armed_o(a_armed), .key_err_o(a_err), .in_vld_i(a_in_vld), .in_rdy_o(a_in_rdy),
    .in_data_i(a_in_data), .out_vld_o(a_out_vld), .out_rdy_i(a_out_rdy), .out_data_o(a_out_data)
  );

  xor_key_lock_pipe #(.DATA_W(8), .KEY_W(8), .STAGES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .key_bit_i(b_key_bit), .key_vld_i(b_key_vld), .key_clr_i(b_key_clr),
    .key_armed_o(b_armed), .key_err_o(b_err), .in_vld_i(b_in_vld), .in_rdy_o(b_in_rdy),
    .in_data_i(b_in_data), .out_vld_o(b_out_vld), .out_rdy_i(b_out_rdy), .out_data_o(b_out_data)
  );

  // sel picks which instance the generic tasks drive and observe.
  logic        sel = 1'b0;
  logic        o_armed, o_err, o_in_rdy, o_vld, cur_in_vld, cur_out_rdy;
  logic [63:0] o_data;
  logic [1:0]  o_state;
  logic [5:0]  o_cnt;
  assign o_armed     = sel ? b_armed : a_armed;
  assign o_err       = sel ? b_err : a_err;
  assign o_in_rdy    = sel ? b_in_rdy : a_in_rdy;
  assign o_vld       = sel ? b_out_vld : a_out_vld;
  assign o_data      = sel ? 64'(b_out_data) : 64'(a_out_data);
  assign o_state     = sel ? dut_b.state_q : dut_a.state_q;
  assign o_cnt       = sel ? 6'(dut_b.cnt_q) : 6'(dut_a.cnt_q);
  assign cur_in_vld  = sel ? b_in_vld : a_in_vld;
  assign cur_out_rdy = sel ? b_out_rdy : a_out_rdy;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] m_key = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int kw();
    return sel ? 8 : 32;
  endfunction

  function automatic int dw();
    return sel ? 8 : 36;
  endfunction

  function automatic logic [63:0] dmask();
    return (64'd1 << dw()) - 64'd1;
  endfunction

  // Reference expansion: lay copies of the key end to end, then trim to the data width.
  function automatic logic [63:0] model_exp();
    logic [63:0] r;
    logic [63:0] k;
    r = '0;
    k = m_key & ((64'd1 << kw()) - 64'd1);
    for (int pos = 0; pos < dw(); pos += kw()) r |= k << pos;
    return r & dmask();
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_key(input logic vld, input logic kbit, input logic clr);
    if (sel) begin b_key_vld = vld; b_key_bit = kbit; b_key_clr = clr; end
    else     begin a_key_vld = vld; a_key_bit = kbit; a_key_clr = clr; end
  endtask

  task automatic drive_in(input logic vld, input logic [63:0] data, input logic rdy);
    if (sel) begin b_in_vld = vld; b_in_data = data[7:0]; b_out_rdy = rdy; end
    else     begin a_in_vld = vld; a_in_data = data[35:0]; a_out_rdy = rdy; end
  endtask

  task automatic load_bits(input logic [63:0] key, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive_key(1'b1, key[i], 1'b0);
      cyc();
    end
    drive_key(1'b0, 1'b0, 1'b0);
  endtask

  task automatic load_full(input logic [63:0] key);
    load_bits(key, 0, kw() - 1);
    m_key = key;
    chk("armed_after_load", o_armed, 1);
  endtask

  task automatic clear_key();
    drive_key(1'b0, 1'b0, 1'b1);
    cyc();
    drive_key(1'b0, 1'b0, 1'b0);
  endtask

  task automatic stream(input int n, input int rdy_pct);
    logic [63:0] q[$];
    logic [63:0] w, prev_data;
    logic        prev_stall;
    int          sent, recv, cycles;
    sent = 0; recv = 0; cycles = 0; prev_stall = 0; prev_data = '0;
    while (recv < n && cycles < 4000) begin
      w = {$urandom, $urandom} & dmask();
      drive_in((sent < n) && ($urandom_range(0, 3) != 0), w, $urandom_range(0, 99) < rdy_pct);
      #1;
      if (prev_stall) begin
        chk("stall_vld", o_vld, 1);
        chk("stall_data", o_data, prev_data);
      end
      if (cur_in_vld && o_in_rdy) begin
        q.push_back(w ^ model_exp());
        sent++;
      end
      if (o_vld && cur_out_rdy) begin
        chk("pending_word", q.size() != 0, 1);
        if (q.size() != 0) chk("out_word", o_data, q.pop_front());
        recv++;
      end
      prev_stall = o_vld && !cur_out_rdy;
      prev_data  = o_data;
      cyc();
      cycles++;
    end
    drive_in(1'b0, '0, 1'b1);
    chk("stream_count", recv, n);
    chk("stream_left", q.size(), 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("no_duplicate", o_vld, 0);
      cyc();
    end
  endtask

  task automatic key_err_test();
    drive_key(1'b1, 1'b1, 1'b0);
    cyc();
    drive_key(1'b0, 1'b0, 1'b0);
    chk("err_set", o_err, 1);
    chk("err_still_armed", o_armed, 1);
    stream(4, 70);
    chk("err_sticky", o_err, 1);
    clear_key();
    chk("err_cleared", o_err, 0);
    chk("clr_disarm", o_armed, 0);
    chk("clr_in_rdy", o_in_rdy, 0);
    chk("clr_state", o_state, IDLE);
  endtask

  task automatic flush_test(input int nwords);
    for (int i = 0; i < nwords; i++) begin
      drive_in(1'b1, {$urandom, $urandom} & dmask(), 1'b0);
      #1;
      chk("flush_fill_rdy", o_in_rdy, 1);
      cyc();
    end
    drive_in(1'b1, {$urandom, $urandom} & dmask(), 1'b0);
    drive_key(1'b0, 1'b0, 1'b1);
    #1;
    chk("flush_in_rdy", o_in_rdy, 0);
    cyc();
    drive_key(1'b0, 1'b0, 1'b0);
    drive_in(1'b0, '0, 1'b1);
    chk("flush_vld", o_vld, 0);
    chk("flush_data", o_data, 0);
    chk("flush_armed", o_armed, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("flush_gone", o_vld, 0);
    end
  endtask

  task automatic accept_vs_clr_test();
    drive_in(1'b1, {$urandom, $urandom} & dmask(), 1'b1);
    #1;
    chk("acc_rdy_before", o_in_rdy, 1);
    drive_key(1'b0, 1'b0, 1'b1);
    #1;
    chk("acc_rdy_clr", o_in_rdy, 0);
    cyc();
    drive_key(1'b0, 1'b0, 1'b0);
    drive_in(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("acc_never_out", o_vld, 0);
      cyc();
    end
  endtask

  logic [63:0] k;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_armed", o_armed, 0);
      chk("rst_err", o_err, 0);
      chk("rst_in_rdy", o_in_rdy, 0);
      chk("rst_out_vld", o_vld, 0);
      chk("rst_out_data", o_data, 0);
      chk("rst_state", o_state, IDLE);
    end
    sel = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Known key, single zero word: output is the expanded key itself.
    load_bits(64'hA5A5A5A5, 0, 30);
    chk("not_armed_31", o_armed, 0);
    load_bits(64'hA5A5A5A5, 31, 31);
    m_key = 64'hA5A5A5A5;
    chk("armed_32", o_armed, 1);
    drive_in(1'b1, '0, 1'b1);
    #1;
    chk("t2_in_rdy", o_in_rdy, 1);
    cyc();
    drive_in(1'b0, '0, 1'b1);
    chk("t2_lat1", o_vld, 0);
    cyc();
    chk("t2_lat2_vld", o_vld, 1);
    chk("t2_data", o_data, 64'h5A5A5A5A5);
    chk("t2_model", o_data, model_exp());
    cyc();
    chk("t2_hold_data", o_data, 64'h5A5A5A5A5);

    stream(8, 50);
    stream(16, 100);

    key_err_test();

    // Partial key then clear: a fresh load must need all 32 bits again.
    k = 64'($urandom);
    load_bits(k, 0, 16);
    chk("partial_cnt", o_cnt, 17);
    clear_key();
    chk("t4_state", o_state, IDLE);
    chk("t4_cnt", o_cnt, 0);
    chk("t4_armed", o_armed, 0);
    k = 64'($urandom);
    load_bits(k, 0, 30);
    chk("t4_not_armed", o_armed, 0);
    load_bits(k, 31, 31);
    m_key = k;
    chk("t4_armed_full", o_armed, 1);
    stream(6, 60);

    flush_test(2);
    load_full(64'($urandom));
    accept_vs_clr_test();

    // Asynchronous reset in the middle of traffic.
    load_full(64'($urandom));
    drive_in(1'b1, 64'h123456789, 1'b1);
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_armed", o_armed, 0);
    chk("t1_in_rdy", o_in_rdy, 0);
    chk("t1_out_vld", o_vld, 0);
    chk("t1_out_data", o_data, 0);
    chk("t1_state", o_state, IDLE);
    drive_in(1'b0, '0, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Small configuration: one stage, key as wide as the data.
    sel = 1'b1;
    #1;
    k = 64'($urandom_range(0, 255));
    load_bits(k, 0, 6);
    chk("b_not_armed_7", o_armed, 0);
    load_bits(k, 7, 7);
    m_key = k;
    chk("b_armed_8", o_armed, 1);
    drive_in(1'b1, 64'h3C, 1'b1);
    cyc();
    drive_in(1'b0, '0, 1'b1);
    chk("b_lat1_vld", o_vld, 1);
    chk("b_lat1_data", o_data, 64'h3C ^ model_exp());
    cyc();
    stream(20, 50);
    key_err_test();
    load_full(64'($urandom_range(0, 255)));
    stream(10, 100);
    flush_test(1);
    load_full(64'($urandom_range(0, 255)));
    accept_vs_clr_test();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
